// File: rtl/hazard_if.sv
// Bundle of decode/pipeline hazard inputs and controller outputs.
// master: pipeline side (drives register/state info, receives controls).
// slave : hazard_ctrl side.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [2:0]       id_rs;
  logic             id_rs_used;
  logic [2:0]       id_rt;
  logic             id_rt_used;
  logic [2:0]       ex_wr_sel;
  logic [2:0]       mem_wr_sel;
  logic [2:0]       wb_wr_sel;
  logic             ex_regwrite;
  logic             mem_regwrite;
  logic             wb_regwrite;
  logic             ex_memread;
  logic             branch_taken;
  logic             mem_busy;
  logic             wb_halt;
  logic             freeze;
  logic             stall_front;
  logic             flush_ifid;
  logic             bubble_idex;
  logic [11:0]      Forwarding_vector;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rs_used, id_rt, id_rt_used,
           ex_wr_sel, mem_wr_sel, wb_wr_sel,
           ex_regwrite, mem_regwrite, wb_regwrite,
           ex_memread, branch_taken, mem_busy, wb_halt,
    input  freeze, stall_front, flush_ifid, bubble_idex,
           Forwarding_vector, halted, stall_count
  );

  modport slave (
    input  id_rs, id_rs_used, id_rt, id_rt_used,
           ex_wr_sel, mem_wr_sel, wb_wr_sel,
           ex_regwrite, mem_regwrite, wb_regwrite,
           ex_memread, branch_taken, mem_busy, wb_halt,
    output freeze, stall_front, flush_ifid, bubble_idex,
           Forwarding_vector, halted, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage processor.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset (forces every output to 0)
//   hif - hazard_if.slave: decode sources, EX/MEM/WB destination and
//         control state in; freeze / stall_front / flush_ifid /
//         bubble_idex / Forwarding_vector / halted / stall_count out.
// Controls are combinational from state and inputs; state and the
// saturating stall counter update on the rising edge.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             load_use;
  logic             count_en;

  assign load_use = hif.ex_memread & hif.ex_regwrite &
                    ((hif.id_rs_used & (hif.id_rs == hif.ex_wr_sel)) |
                     (hif.id_rt_used & (hif.id_rt == hif.ex_wr_sel)));

  always_comb begin
    state_next            = state;
    hif.freeze            = 1'b0;
    hif.stall_front       = 1'b0;
    hif.flush_ifid        = 1'b0;
    hif.bubble_idex       = 1'b0;
    hif.Forwarding_vector = '0;
    if (!rst) begin
      case (state)
        HALTED: begin
          hif.freeze = 1'b1;
        end
        RUN, MEMWAIT: begin
          hif.Forwarding_vector = {hif.wb_regwrite, hif.wb_wr_sel,
                                   hif.mem_regwrite, hif.mem_wr_sel,
                                   hif.ex_regwrite & ~hif.ex_memread,
                                   hif.ex_wr_sel};
          if (hif.mem_busy) begin
            hif.freeze = 1'b1;
            state_next = MEMWAIT;
          end else if (hif.wb_halt) begin
            // Also taken on the MEMWAIT release cycle: WB was held during
            // the wait, so a HALT arriving with mem_busy must retire here.
            state_next = HALTED;
          end else begin
            state_next = RUN;
            if (hif.branch_taken) begin
              // Squashing the dependent instruction makes any load-use moot.
              hif.flush_ifid  = 1'b1;
              hif.bubble_idex = 1'b1;
            end else if (load_use) begin
              hif.stall_front = 1'b1;
              hif.bubble_idex = 1'b1;
            end
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign count_en = (state != HALTED) &
                    (hif.freeze | hif.stall_front | hif.bubble_idex);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_next;
      if (count_en && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign hif.halted      = ~rst & (state == HALTED);
  assign hif.stall_count = rst ? '0 : count;

endmodule
